// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - frame-level scheduler sharing one Ethernet TX engine between ARP and UDP
module eth_tx_sched #(
   parameter int DATA_W         = 32,
   parameter int GAP_CYCLES     = 12,
   parameter int ARP_BURST_MAX  = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              arp_req,
   input  logic              arp_req_oper,
   output logic              arp_pending,
   output logic              arp_drop,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic              tx_arp_start,
   output logic              tx_arp_oper,
   input  logic              tx_arp_done,
   input  logic              tx_busy,
   output logic [1:0]        grant,
   output logic              timeout_err
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(ARP_BURST_MAX + 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] STREAK_MAX = SW'(ARP_BURST_MAX);

   typedef enum logic [2:0] {
      S_IDLE, S_ARP_START, S_ARP_WAIT, S_UDP_XFER, S_UDP_DRAIN, S_GAP
   } state_t;

   // A zero gap skips the GAP state entirely.
   localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

   state_t          state_q, state_d;
   logic            pend_q, pend_d;
   logic            pend_oper_q, pend_oper_d;
   logic            oper_q, oper_d;
   logic            drop_q, drop_d;
   logic [SW-1:0]   streak_q, streak_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            take_arp, take_udp, tmo_hit, udp_last;

   // State and bookkeeping registers with synchronous reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= S_IDLE;
         pend_q      <= 1'b0;
         pend_oper_q <= 1'b0;
         oper_q      <= 1'b0;
         drop_q      <= 1'b0;
         streak_q    <= '0;
         gap_q       <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_oper_q <= pend_oper_d;
         oper_q      <= oper_d;
         drop_q      <= drop_d;
         streak_q    <= streak_d;
         gap_q       <= gap_d;
         tmo_q       <= tmo_d;
      end
   end

   // Next-state: arbitration, pending latch, gap and timeout counters
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_oper_d = pend_oper_q;
      oper_d      = oper_q;
      streak_d    = streak_q;
      gap_d       = '0;
      tmo_d       = '0;
      tmo_hit     = (tmo_q == TMO_MAX);
      udp_last    = s_axis_tvalid && m_axis_tready && s_axis_tlast;
      take_arp    = (state_q == S_IDLE) && pend_q &&
                    ((streak_q < STREAK_MAX) || !s_axis_tvalid);
      take_udp    = (state_q == S_IDLE) && !take_arp && s_axis_tvalid;

      case (state_q)
         S_IDLE: begin
            if (take_arp) begin
               state_d = S_ARP_START;
               oper_d  = pend_oper_q;
               pend_d  = 1'b0;
               if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
            end else if (take_udp) begin
               state_d  = S_UDP_XFER;
               streak_d = '0;
            end
         end
         S_ARP_START: state_d = S_ARP_WAIT;
         S_ARP_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            if (tx_arp_done || tmo_hit) state_d = AFTER_FRAME;
         end
         S_UDP_XFER: begin
            if (udp_last) state_d = S_UDP_DRAIN;
         end
         S_UDP_DRAIN: begin
            tmo_d = tmo_q + 1'b1;
            if (!tx_busy || tmo_hit) state_d = AFTER_FRAME;
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = S_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // A request in the same cycle ARP is granted re-arms pending rather than coalescing.
      drop_d = arp_req && pend_q && !take_arp;
      if (arp_req) begin
         pend_d      = 1'b1;
         pend_oper_d = arp_req_oper;
      end
   end

   // Outputs decoded from state; UDP stream is gated to pass only while UDP owns the engine
   always_comb begin
      grant         = 2'b00;
      tx_arp_start  = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = 1'b0;
      timeout_err   = 1'b0;
      case (state_q)
         S_ARP_START: begin
            grant        = 2'b01;
            tx_arp_start = 1'b1;
         end
         S_ARP_WAIT: begin
            grant       = 2'b01;
            timeout_err = tmo_hit && !tx_arp_done;
         end
         S_UDP_XFER: begin
            grant         = 2'b10;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            s_axis_tready = m_axis_tready;
         end
         S_UDP_DRAIN: begin
            grant       = 2'b10;
            timeout_err = tmo_hit && tx_busy;
         end
         default: ;
      endcase
   end

   assign m_axis_tdata = s_axis_tdata;
   assign arp_pending  = pend_q;
   assign arp_drop     = drop_q;
   assign tx_arp_oper  = oper_q;

endmodule
